// File: rtl/addsub_pipe_nb.sv
// Pipelined N-bit add/subtract, one K-bit carry chunk per register stage.
// Valid/ready handshake on both sides; one operation per cycle.
`timescale 1ns/1ps
module addsub_pipe_nb #(
  parameter int N = 32,
  parameter int K = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         co,
  output logic         v,
  output logic         z
);

  localparam int S = N / K;

  logic stall;
  logic adv;

  assign stall    = out_valid && !out_ready;
  assign adv      = !stall;
  assign in_ready = !stall;

  for (genvar i = 0; i < S; i++) begin : stg
    // RW: operand bits still unprocessed entering this stage
    localparam int RW = N - i * K;
    localparam int SW = (i + 1) * K;

    logic          vld_d;
    logic          c_d;
    logic [RW-1:0] a_d;
    logic [RW-1:0] b_d;
    logic [K:0]    part;
    logic [SW-1:0] s_n;

    logic          vld_q;
    logic          c_q;
    logic [SW-1:0] s_q;

    if (i == 0) begin : g_src
      assign vld_d = in_valid;
      assign c_d   = cin ^ sub;
      assign a_d   = a;
      assign b_d   = b ^ {N{sub}};
      assign s_n   = part[K-1:0];
    end else begin : g_src
      assign vld_d = stg[i-1].vld_q;
      assign c_d   = stg[i-1].c_q;
      assign a_d   = stg[i-1].g_fwd.a_q;
      assign b_d   = stg[i-1].g_fwd.b_q;
      assign s_n   = {part[K-1:0], stg[i-1].s_q};
    end

    assign part = {1'b0, a_d[K-1:0]}
                + {1'b0, b_d[K-1:0]}
                + {{K{1'b0}}, c_d};

    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        s_q   <= '0;
      end else if (adv) begin
        vld_q <= vld_d;
        if (vld_d) begin
          c_q <= part[K];
          s_q <= s_n;
        end
      end
    end

    if (i < S - 1) begin : g_fwd
      logic [RW-K-1:0] a_q;
      logic [RW-K-1:0] b_q;

      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv && vld_d) begin
          a_q <= a_d[RW-1:K];
          b_q <= b_d[RW-1:K];
        end
      end
    end else begin : g_last
      logic v_q;
      logic z_q;

      // carry into the top bit recovered from the top sum bit
      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          v_q <= 1'b0;
          z_q <= 1'b0;
        end else if (adv && vld_d) begin
          v_q <= part[K] ^ part[K-1]
               ^ a_d[K-1] ^ b_d[K-1];
          z_q <= ~|s_n;
        end
      end
    end
  end

  assign out_valid = stg[S-1].vld_q;
  assign sum       = stg[S-1].s_q;
  assign co        = stg[S-1].c_q;
  assign v         = stg[S-1].g_last.v_q;
  assign z         = stg[S-1].g_last.z_q;

endmodule

// File: tb/tb_addsub_pipe_nb.sv
// Self-checking bench for addsub_pipe_nb (N=32, K=8).
// Directed table, backpressure, mid-stream reset and random traffic.
`timescale 1ns/1ps
module tb_addsub_pipe_nb;
  localparam int N = 32;
  localparam int K = 8;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] sum;
  logic         co;
  logic         v;
  logic         z;

  int n_chk = 0;
  int n_fail = 0;
  int n_out = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        co;
    logic        v;
    logic        z;
  } vec_t;

  vec_t tbl[12];

  logic [34:0] q[$];
  logic [34:0] prev = '0;
  logic        prev_stall = 1'b0;

  addsub_pipe_nb #(.N(N), .K(K)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .cin(cin),
    .sub(sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .co(co),
    .v(v),
    .z(z)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // returns {co, v, z, sum}
  function automatic logic [34:0] model(input logic [31:0] ia,
                                        input logic [31:0] ib,
                                        input logic ic,
                                        input logic is);
    logic [31:0] bb;
    logic [32:0] r;
    logic        ov;
    bb = is ? ~ib : ib;
    r  = {1'b0, ia} + {1'b0, bb} + {32'd0, ic ^ is};
    ov = (ia[31] == bb[31]) && (r[31] != ia[31]);
    return {r[32], ov, (r[31:0] == 32'd0), r[31:0]};
  endfunction

  // one cycle: called at negedge, returns at the next negedge
  task automatic cyc(input logic iv,
                     input logic [31:0] ia,
                     input logic [31:0] ib,
                     input logic ic,
                     input logic is,
                     input logic ordy,
                     output logic acc);
    logic        st;
    logic        cons;
    logic [34:0] got;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    cin       = ic;
    sub       = is;
    out_ready = ordy;
    #1;
    st  = out_valid && !ordy;
    got = {co, v, z, sum};
    chk("in_ready", {63'd0, in_ready}, {63'd0, !st});
    if (q.size() == 0)
      chk("spurious_out", {63'd0, out_valid}, 64'd0);
    else if (out_valid)
      chk("result", {29'd0, got}, {29'd0, q[0]});
    if (prev_stall)
      chk("hold", {28'd0, out_valid, got}, {28'd0, 1'b1, prev});
    acc  = iv && in_ready;
    cons = out_valid && ordy;
    prev_stall = st;
    prev = got;
    @(posedge CLK);
    if (acc) q.push_back(model(ia, ib, ic, is));
    if (cons && q.size() > 0) begin
      void'(q.pop_front());
      n_out++;
    end
    @(negedge CLK);
  endtask

  task automatic drain();
    logic acc;
    int   d;
    d = 0;
    while (q.size() > 0 && d < 50) begin
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
      d++;
    end
    chk("drain_empty", q.size(), 64'd0);
  endtask

  initial begin
    logic acc;
    int   lat;
    int   k;
    int   c;
    int   n0;

    tbl[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0,
                32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1,
                32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{32'h00000007, 32'h00000005, 1'b1, 1'b1,
                32'h00000001, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0,
                32'h80000000, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1,
                32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{32'h12345678, 32'h87654321, 1'b1, 1'b0,
                32'h9999999A, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b1,
                32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b0,
                32'h00000001, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0,
                32'h00000000, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{32'h00000005, 32'h00000005, 1'b0, 1'b1,
                32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0,
                32'h00000100, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0,
                32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};

    // reset with random inputs
    RST_N = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      in_valid  = 1'($urandom_range(0, 1));
      a         = $urandom;
      b         = $urandom;
      cin       = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(posedge CLK);
    end
    @(negedge CLK);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sum", {32'd0, sum}, 64'd0);
    chk("rst_flags", {61'd0, co, v, z}, 64'd0);
    RST_N     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge CLK);
    @(negedge CLK);

    // directed table, one op at a time
    for (int i = 0; i < 12; i++) begin
      in_valid  = 1'b1;
      a         = tbl[i].a;
      b         = tbl[i].b;
      cin       = tbl[i].cin;
      sub       = tbl[i].sub;
      out_ready = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(posedge CLK);
        @(negedge CLK);
        lat++;
      end
      chk($sformatf("latency%0d", i), lat, 64'd4);
      chk($sformatf("vec%0d", i),
          {29'd0, co, v, z, sum},
          {29'd0, tbl[i].co, tbl[i].v, tbl[i].z, tbl[i].sum});
    end
    @(posedge CLK);
    @(negedge CLK);

    // backpressure: 8 back-to-back ops, out_ready toggling
    n0 = n_out;
    k  = 0;
    c  = 0;
    while (k < 8 && c < 100) begin
      cyc(1'b1, 32'h11111111 * k + 32'hF0, 32'h0F0F0F0F ^ k,
          1'(k % 2), 1'(k / 4), (c % 2) == 0, acc);
      if (acc) k++;
      c++;
    end
    chk("bp_issued", k, 64'd8);
    drain();
    chk("bp_count", n_out - n0, 64'd8);

    // reset with three ops in flight
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 32'h100 + i, 32'h3, 1'b0, 1'b0, 1'b1, acc);
    RST_N    = 1'b0;
    in_valid = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    q.delete();
    prev_stall = 1'b0;
    RST_N = 1'b1;
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc);

    // random traffic against the reference model
    n0 = n_out;
    k  = 0;
    c  = 0;
    while (k < 1000 && c < 5000) begin
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 2) != 0, acc);
      if (acc) k++;
      c++;
    end
    chk("rand_issued", k, 64'd1000);
    drain();
    chk("rand_count", n_out - n0, 64'd1000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
